// File: rtl/axi_slv_pkg.sv
// ---------------------------------------------------------------------------
// axi_slv_pkg
// Shared types and helpers for the AXI3 SRAM responder:
//   burst_t    - AXI burst encodings (FIXED / INCR / WRAP / reserved)
//   RESP_OKAY  - the only response code this responder ever returns
//   r_state_t  - read channel FSM states
//   w_state_t  - write channel FSM states
//   eff_size   - AxSIZE clamped to the 32-bit data bus (size > 2 acts as 2)
//   beat_bytes - byte stride of one beat for a given AxSIZE
// ---------------------------------------------------------------------------
package axi_slv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_t;

  // The data bus is 32 bits wide, so anything wider than a word is a word.
  function automatic logic [1:0] eff_size(input logic [2:0] size);
    return (size > 3'd2) ? 2'd2 : size[1:0];
  endfunction

  function automatic logic [31:0] beat_bytes(input logic [2:0] size);
    return 32'd1 << eff_size(size);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational next-beat address for an AXI3 burst.
// Ports:
//   addr      in  32  address of the current beat
//   len       in  8   AxLEN (beats - 1), used for the WRAP window
//   size      in  3   AxSIZE, clamped to a word
//   burst     in  2   AxBURST; the reserved code behaves as INCR
//   next_addr out 32  address of the following beat
// ---------------------------------------------------------------------------
module axi_burst_addr_gen
  import axi_slv_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;

  // WRAP keeps the upper bits of the aligned (len+1)<<size window and lets
  // only the low bits of the incremented address roll over inside it.
  always_comb begin
    incr_addr = addr + beat_bytes(size);
    wrap_mask = (({24'd0, len} + 32'd1) << eff_size(size)) - 32'd1;
    case (burst_t'(burst))
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// ---------------------------------------------------------------------------
// axi_sram_slave
// AXI3 responder backed by a word-addressed SRAM of 2**ADDR_BITS words.
// Read and write channels run independent FSMs, one transaction each.
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   ar*/r*                 read address / read data channels
//   aw*/w*/b*              write address / write data / write response
//   *lock, *cache, *prot, wid are accepted and ignored
// Optional feature (macro AXI_SLV_RAND_STALL_EN): a 16-bit LFSR seeded
// with LFSR_SEED drops the readies about one cycle in four and delays
// each read beat and the write response by 0-3 cycles.
// ---------------------------------------------------------------------------
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int          ADDR_BITS = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  r_state_t    r_state, r_state_next;
  w_state_t    w_state, w_state_next;
  logic        ready_en;
  logic [31:0] r_addr, r_next, w_addr, w_next;
  logic [7:0]  r_len, r_cnt, w_len;
  logic [2:0]  r_size, w_size;
  logic [1:0]  r_burst, w_burst;
  logic        ar_hs, r_hs, aw_hs, w_hs;
  logic        stall, r_wait, b_wait;
  logic        unused_inputs;

  assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign rresp = RESP_OKAY;
  assign bresp = RESP_OKAY;
  assign rlast = (r_state == R_DATA) && (r_cnt == r_len);

`ifdef AXI_SLV_RAND_STALL_EN
  logic [15:0] lfsr;
  logic [1:0]  r_dly, b_dly;

  // Free-running LFSR (taps 16,14,13,11). A delay counter is loaded when a
  // beat or the response becomes due and valid is held off until it drains,
  // so once valid rises nothing can pull it back down before the handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr  <= LFSR_SEED;
      r_dly <= 2'd0;
      b_dly <= 2'd0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (ar_hs || (r_hs && !rlast)) r_dly <= lfsr[3:2];
      else if (r_dly != 2'd0)        r_dly <= r_dly - 2'd1;
      if (w_hs && wlast)             b_dly <= lfsr[5:4];
      else if (b_dly != 2'd0)        b_dly <= b_dly - 2'd1;
    end
  end

  assign stall  = (lfsr[1:0] == 2'b00);
  assign r_wait = (r_dly != 2'd0);
  assign b_wait = (b_dly != 2'd0);
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign stall  = 1'b0;
  assign r_wait = 1'b0;
  assign b_wait = 1'b0;
`endif

  axi_burst_addr_gen u_rd_gen (
    .addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst), .next_addr(r_next)
  );

  axi_burst_addr_gen u_wr_gen (
    .addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst), .next_addr(w_next)
  );

  // Keeps the readies low while reset is asserted and for the edge that
  // releases it, so they first rise the cycle after aresetn goes high.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_state_next;
      w_state <= w_state_next;
    end
  end

  // Read FSM: accept AR in idle, then present beats until the last one
  // is taken.
  always_comb begin
    r_state_next = r_state;
    arready      = 1'b0;
    rvalid       = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = ready_en && !stall;
        if (arvalid && arready) r_state_next = R_DATA;
      end
      R_DATA: begin
        rvalid = !r_wait;
        if (rvalid && rready && rlast) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Write FSM: W is refused until AW is taken, so early data simply waits.
  // wlast, not the beat count, ends the data phase.
  always_comb begin
    w_state_next = w_state;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = ready_en && !stall;
        if (awvalid && awready) w_state_next = W_DATA;
      end
      W_DATA: begin
        wready = !stall;
        if (wvalid && wready && wlast) w_state_next = W_RESP;
      end
      W_RESP: begin
        bvalid = !b_wait;
        if (bvalid && bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  // Read datapath. rdata is fetched one beat ahead: on the AR handshake and
  // on every accepted non-last beat, so it stays put while rready is low.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rid     <= 4'd0;
      r_addr  <= 32'd0;
      r_len   <= 8'd0;
      r_size  <= 3'd0;
      r_burst <= 2'd0;
      r_cnt   <= 8'd0;
      rdata   <= 32'd0;
    end else if (ar_hs) begin
      rid     <= arid;
      r_addr  <= araddr;
      r_len   <= arlen;
      r_size  <= arsize;
      r_burst <= arburst;
      r_cnt   <= 8'd0;
      rdata   <= mem[araddr[ADDR_BITS+1:2]];
    end else if (r_hs && !rlast) begin
      r_addr <= r_next;
      r_cnt  <= r_cnt + 8'd1;
      rdata  <= mem[r_next[ADDR_BITS+1:2]];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bid     <= 4'd0;
      w_addr  <= 32'd0;
      w_len   <= 8'd0;
      w_size  <= 3'd0;
      w_burst <= 2'd0;
    end else if (aw_hs) begin
      bid     <= awid;
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
    end else if (w_hs) begin
      w_addr <= w_next;
    end
  end

  // SRAM write port. Contents survive reset; a read fetched on the same
  // edge as a write sees the old word.
  always_ff @(posedge aclk) begin
    if (w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[w_addr[ADDR_BITS+1:2]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_sram_slave
// Self-checking bench for axi_sram_slave: a table of single-beat writes and
// reads with hand-computed results, followed by hand-written multi-beat
// sequences (INCR, WRAP, sub-word size, FIXED, reserved burst, early wlast,
// rready back-pressure and reset in the middle of a read burst).
// ---------------------------------------------------------------------------
module tb_axi_sram_slave;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = '0, awsize = '0, arprot = '0, awprot = '0;
  logic [1:0]  arburst = '0, awburst = '0, arlock = '0, awlock = '0;
  logic [3:0]  arcache = '0, awcache = '0, wstrb = '0;
  logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0, rlast;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, wlast = 1'b0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  rresp, bresp;

  int          n_compared = 0;
  int          n_mismatched = 0;
  logic [31:0] beat_data [16];

  typedef struct {
    logic        wr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  always #5 aclk = ~aclk;

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: got no handshake, expected one within 100 cycles", name);
  endtask

  // All tasks start and end on a falling edge.
  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input string tag);
    int t = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    while (!arready && t < 100) begin @(negedge aclk); t++; end
    if (t >= 100) timeout_fail({tag, "_ar"});
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic wait_rvalid(input string tag);
    int t = 0;
    while (!rvalid && t < 100) begin @(negedge aclk); t++; end
    if (t >= 100) timeout_fail(tag);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input int nbeats,
                          input logic [3:0] strb, input string tag);
    int t = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    while (!awready && t < 100) begin @(negedge aclk); t++; end
    if (t >= 100) timeout_fail({tag, "_aw"});
    @(negedge aclk);
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      wdata = beat_data[b]; wstrb = strb; wlast = (b == nbeats - 1);
      wvalid = 1'b1;
      t = 0;
      while (!wready && t < 100) begin @(negedge aclk); t++; end
      if (t >= 100) timeout_fail($sformatf("%s_w%0d", tag, b));
      @(negedge aclk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid && t < 100) begin @(negedge aclk); t++; end
    if (t >= 100) timeout_fail({tag, "_b"});
    else begin
      check_output({tag, "_bid"}, 32'(bid), 32'(id));
      check_output({tag, "_bresp"}, 32'(bresp), 32'd0);
    end
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input string tag);
    ar_send(id, addr, len, size, burst, tag);
    rready = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      wait_rvalid($sformatf("%s_r%0d", tag, b));
      check_output($sformatf("%s_b%0d_data", tag, b), rdata, beat_data[b]);
      check_output($sformatf("%s_b%0d_last", tag, b), 32'(rlast), 32'(b == int'(len)));
      if (b == 0) begin
        check_output({tag, "_rid"}, 32'(rid), 32'(id));
        check_output({tag, "_rresp"}, 32'(rresp), 32'd0);
      end
      @(negedge aclk);
    end
    rready = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    string tag = $sformatf("vec%0d", idx);
    if (v.wr) begin
      beat_data[0] = v.data;
      do_write(v.id, v.addr, 8'd0, 3'd2, 2'b01, 1, v.strb, tag);
    end else begin
      beat_data[0] = v.exp;
      do_read(v.id, v.addr, 8'd0, 3'd2, 2'b01, tag);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 4'h3, 32'h1C00_0000, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 4'h5, 32'h1C00_0000, 32'h0,         4'h0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 4'h1, 32'h0000_0200, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[3] = '{1'b1, 4'h2, 32'h0000_0200, 32'h1122_3344, 4'h5, 32'h0};
    vecs[4] = '{1'b0, 4'h7, 32'h0000_0200, 32'h0,         4'h0, 32'hFF22_FF44};
    vecs[5] = '{1'b1, 4'hA, 32'h0004_0004, 32'hCAFE_F00D, 4'hF, 32'h0};
    vecs[6] = '{1'b0, 4'hB, 32'h0000_0004, 32'h0,         4'h0, 32'hCAFE_F00D};
    vecs[7] = '{1'b1, 4'hC, 32'h0000_0200, 32'h9988_7766, 4'hA, 32'h0};
    vecs[8] = '{1'b0, 4'hD, 32'h0000_0200, 32'h0,         4'h0, 32'h9922_7744};

    // Reset state.
    repeat (3) @(negedge aclk);
    check_output("rst_arready", 32'(arready), 32'd0);
    check_output("rst_awready", 32'(awready), 32'd0);
    check_output("rst_wready",  32'(wready),  32'd0);
    check_output("rst_rvalid",  32'(rvalid),  32'd0);
    check_output("rst_rlast",   32'(rlast),   32'd0);
    check_output("rst_bvalid",  32'(bvalid),  32'd0);
    check_output("rst_rdata",   rdata,        32'd0);
    aresetn = 1'b1;
    @(negedge aclk);
    check_output("post_rst_arready", 32'(arready), 32'd1);
    check_output("post_rst_awready", 32'(awready), 32'd1);
    check_output("post_rst_wready",  32'(wready),  32'd0);

    for (int i = 0; i < 9; i++) apply_stimulus(vecs[i], i);

    // INCR burst write then read back.
    for (int i = 0; i < 4; i++) beat_data[i] = 32'(i + 1);
    do_write(4'h4, 32'h100, 8'd3, 3'd2, 2'b01, 4, 4'hF, "incr_wr");
    do_read(4'h4, 32'h100, 8'd3, 3'd2, 2'b01, "incr_rd");

    // WRAP from 0x108 visits 0x108, 0x10C, 0x100, 0x104.
    beat_data[0] = 32'd3; beat_data[1] = 32'd4;
    beat_data[2] = 32'd1; beat_data[3] = 32'd2;
    do_read(4'h6, 32'h108, 8'd3, 3'd2, 2'b10, "wrap_rd");

    // Byte-sized INCR beats all land in word 0x100.
    for (int i = 0; i < 3; i++) beat_data[i] = 32'd1;
    do_read(4'h8, 32'h101, 8'd2, 3'd0, 2'b01, "byte_rd");

    // Reserved burst code behaves as INCR.
    beat_data[0] = 32'd2; beat_data[1] = 32'd3;
    do_read(4'h9, 32'h104, 8'd1, 3'd2, 2'b11, "rsvd_rd");

    // FIXED write: both beats hit 0x300, the second wins.
    beat_data[0] = 32'h0000_000A; beat_data[1] = 32'h0000_000B;
    do_write(4'h2, 32'h300, 8'd1, 3'd2, 2'b00, 2, 4'hF, "fixed_wr");
    beat_data[0] = 32'h0000_000B;
    do_read(4'h2, 32'h300, 8'd0, 3'd2, 2'b01, "fixed_rd");

    // wlast on beat 1 of a len3 burst ends the write.
    beat_data[0] = 32'h55; beat_data[1] = 32'h66;
    do_write(4'hF, 32'h400, 8'd3, 3'd2, 2'b01, 2, 4'hF, "early_wr");
    check_output("early_wr_awready", 32'(awready), 32'd1);
    do_read(4'hF, 32'h400, 8'd1, 3'd2, 2'b01, "early_rd");

    // rready held low for 5 cycles on beat 1.
    ar_send(4'h9, 32'h100, 8'd3, 3'd2, 2'b01, "bp");
    rready = 1'b1;
    wait_rvalid("bp_r0");
    check_output("bp_b0_data", rdata, 32'd1);
    @(negedge aclk);
    rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("bp_hold%0d_valid", i), 32'(rvalid), 32'd1);
      check_output($sformatf("bp_hold%0d_data", i), rdata, 32'd2);
      check_output($sformatf("bp_hold%0d_last", i), 32'(rlast), 32'd0);
      @(negedge aclk);
    end
    rready = 1'b1;
    for (int b = 1; b < 4; b++) begin
      wait_rvalid($sformatf("bp_r%0d", b));
      check_output($sformatf("bp_b%0d_data", b), rdata, 32'(b + 1));
      check_output($sformatf("bp_b%0d_last", b), 32'(rlast), 32'(b == 3));
      @(negedge aclk);
    end
    rready = 1'b0;

    // Reset during beat 2 of a len7 read.
    ar_send(4'h2, 32'h100, 8'd7, 3'd2, 2'b01, "rst_mid");
    rready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      wait_rvalid($sformatf("rst_mid_r%0d", b));
      check_output($sformatf("rst_mid_b%0d_data", b), rdata, 32'(b + 1));
      @(negedge aclk);
    end
    rready = 1'b0;
    check_output("rst_mid_b2_data", rdata, 32'd3);
    aresetn = 1'b0;
    #1;
    check_output("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check_output("rst_mid_rlast",  32'(rlast),  32'd0);
    check_output("rst_mid_arready", 32'(arready), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check_output("rst_mid_rearm_arready", 32'(arready), 32'd1);
    check_output("rst_mid_rearm_rvalid", 32'(rvalid), 32'd0);
    beat_data[0] = 32'hDEAD_BEEF;
    do_read(4'hE, 32'h1C00_0000, 8'd0, 3'd2, 2'b01, "post_rst_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
